// File: rtl/writeback_pkg.sv
// Shared writeback definitions: result-source encodings and load funct3 codes.
// The optional retired-instruction counter is enabled with the WB_INSTRET_EN macro.
package writeback_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'b00,
    WB_SRC_LOAD = 2'b01,
    WB_SRC_PC4  = 2'b10,
    WB_SRC_NONE = 2'b11
  } wb_src_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // A retiring entry writes the register file only if it has a result and rd is not x0.
  function automatic logic wb_writes(input wb_src_e src, input logic is_x0);
    return (src != WB_SRC_NONE) && !is_x0;
  endfunction

endpackage

// File: rtl/writeback_if.sv
// Memory-stage to writeback handshake plus the register-file write port.
interface writeback_if #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int PC_WIDTH    = 32
);
  logic                   wb_i_valid;
  logic                   wb_o_ready;
  logic                   wb_i_flush;
  logic                   wb_i_stall;
  logic [1:0]             wb_i_src;
  logic [FUNCT_WIDTH-1:0] wb_i_funct3;
  logic [1:0]             wb_i_byte_off;
  logic [AWIDTH-1:0]      wb_i_addr_rd;
  logic [DWIDTH-1:0]      wb_i_alu;
  logic [DWIDTH-1:0]      wb_i_load;
  logic [PC_WIDTH-1:0]    wb_i_pc;
  logic                   wb_o_we;
  logic [AWIDTH-1:0]      wb_o_addr_rd;
  logic [DWIDTH-1:0]      wb_o_data_rd;

  modport master (
    output wb_i_valid, wb_i_flush, wb_i_stall, wb_i_src, wb_i_funct3,
           wb_i_byte_off, wb_i_addr_rd, wb_i_alu, wb_i_load, wb_i_pc,
    input  wb_o_ready, wb_o_we, wb_o_addr_rd, wb_o_data_rd
  );

  modport slave (
    input  wb_i_valid, wb_i_flush, wb_i_stall, wb_i_src, wb_i_funct3,
           wb_i_byte_off, wb_i_addr_rd, wb_i_alu, wb_i_load, wb_i_pc,
    output wb_o_ready, wb_o_we, wb_o_addr_rd, wb_o_data_rd
  );
endinterface

// File: rtl/writeback_load_ext.sv
// wb_load_ext: combinational byte/halfword lane select and sign/zero extension
// of a raw aligned load word. Undefined funct3 codes pass the raw word through.
module wb_load_ext
  import writeback_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic [FUNCT_WIDTH-1:0] i_funct3,
  input  logic [1:0]             i_byte_off,
  input  logic [DWIDTH-1:0]      i_word,
  output logic [DWIDTH-1:0]      o_data
);

  function automatic logic [DWIDTH-1:0] sext8(input logic signed [7:0] b);
    return DWIDTH'(b);
  endfunction

  function automatic logic [DWIDTH-1:0] zext8(input logic signed [7:0] b);
    return DWIDTH'($unsigned(b));
  endfunction

  function automatic logic [DWIDTH-1:0] sext16(input logic signed [15:0] h);
    return DWIDTH'(h);
  endfunction

  function automatic logic [DWIDTH-1:0] zext16(input logic signed [15:0] h);
    return DWIDTH'($unsigned(h));
  endfunction

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  assign w_byte = i_word[{i_byte_off, 3'b000} +: 8];
  assign w_half = i_word[{i_byte_off[1], 4'b0000} +: 16];

  // Pick the lane and extension rule from the load type.
  always_comb begin
    o_data = i_word;
    case (i_funct3)
      FUNCT_WIDTH'(FUNCT3_LB):  o_data = sext8(w_byte);
      FUNCT_WIDTH'(FUNCT3_LBU): o_data = zext8(w_byte);
      FUNCT_WIDTH'(FUNCT3_LH):  o_data = sext16(w_half);
      FUNCT_WIDTH'(FUNCT3_LHU): o_data = zext16(w_half);
      default:                  o_data = i_word;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// writeback: final pipeline stage. Two-entry skid buffer fed by the memory stage,
// result select/extension, and a registered register-file write port.
// Define WB_INSTRET_EN to add the 64-bit retired-instruction counter output.
module writeback
  import writeback_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int FUNCT_WIDTH = 3,
  parameter int PC_WIDTH    = 32
) (
  input  logic        c_clk,
  input  logic        c_rst,
  writeback_if.slave  wb
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] wb_o_instret
`endif
);

  typedef struct packed {
    wb_src_e                src;
    logic [FUNCT_WIDTH-1:0] funct3;
    logic [1:0]             byte_off;
    logic [AWIDTH-1:0]      rd;
    logic [DWIDTH-1:0]      alu;
    logic [DWIDTH-1:0]      load;
    logic [PC_WIDTH-1:0]    pc;
  } wb_entry_t;

  wb_entry_t         r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_push;
  logic              w_pop;
  wb_entry_t         w_in_p0;
  wb_entry_t         w_head_p0;
  logic [DWIDTH-1:0] w_load_ext_p0;
  logic [DWIDTH-1:0] w_sel_p0;
  logic [PC_WIDTH-1:0] w_pc4_p0;

  logic              r_we_p1;
  logic [AWIDTH-1:0] r_addr_p1;
  logic [DWIDTH-1:0] r_data_p1;

  // Ready depends on occupancy only so the upstream never sees a combinational loop.
  assign wb.wb_o_ready = (r_count < 2'd2);
  assign w_push = wb.wb_i_valid && wb.wb_o_ready && !wb.wb_i_flush;
  assign w_pop  = (r_count != 2'd0) && !wb.wb_i_stall && !wb.wb_i_flush;

  assign w_in_p0 = '{
    src:      wb_src_e'(wb.wb_i_src),
    funct3:   wb.wb_i_funct3,
    byte_off: wb.wb_i_byte_off,
    rd:       wb.wb_i_addr_rd,
    alu:      wb.wb_i_alu,
    load:     wb.wb_i_load,
    pc:       wb.wb_i_pc
  };

  // Buffer storage: payload only, occupancy tracking lives in the control block.
  always_ff @(posedge c_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_p0;
  end

  // Occupancy and pointers; flush empties the buffer and drops the same-cycle push.
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (wb.wb_i_flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- stage p0: head of buffer, result select ----
  assign w_head_p0 = r_mem[r_rd_ptr];
  assign w_pc4_p0  = w_head_p0.pc + PC_WIDTH'(4);

  wb_load_ext #(
    .DWIDTH      (DWIDTH),
    .FUNCT_WIDTH (FUNCT_WIDTH)
  ) u_load_ext (
    .i_funct3   (w_head_p0.funct3),
    .i_byte_off (w_head_p0.byte_off),
    .i_word     (w_head_p0.load),
    .o_data     (w_load_ext_p0)
  );

  // Choose the value written back according to the result source.
  always_comb begin
    w_sel_p0 = w_head_p0.alu;
    case (w_head_p0.src)
      WB_SRC_ALU:  w_sel_p0 = w_head_p0.alu;
      WB_SRC_LOAD: w_sel_p0 = w_load_ext_p0;
      WB_SRC_PC4:  w_sel_p0 = DWIDTH'(w_pc4_p0);
      default:     w_sel_p0 = w_head_p0.alu;
    endcase
  end

  // ---- stage p1: registered register-file write port ----
  // Address/data hold when nothing pops; the enable is a one-cycle pulse per pop.
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      r_we_p1   <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
    end else if (w_pop) begin
      r_we_p1   <= wb_writes(w_head_p0.src, (w_head_p0.rd == '0));
      r_addr_p1 <= w_head_p0.rd;
      r_data_p1 <= w_sel_p0;
    end else begin
      r_we_p1   <= 1'b0;
    end
  end

  assign wb.wb_o_we      = r_we_p1;
  assign wb.wb_o_addr_rd = r_addr_p1;
  assign wb.wb_o_data_rd = r_data_p1;

`ifdef WB_INSTRET_EN
  logic [63:0] r_instret;

  // Count every pop, including no-write entries; flushed entries never pop.
  always_ff @(posedge c_clk or posedge c_rst) begin
    if (c_rst)      r_instret <= 64'd0;
    else if (w_pop) r_instret <= r_instret + 64'd1;
  end

  assign wb_o_instret = r_instret;
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: queue-based reference model, per-cycle
// compare process, directed literal checks and a randomized phase.
module tb_writeback;

  logic c_clk = 1'b0;
  logic c_rst = 1'b1;
  always #5 c_clk = ~c_clk;

  writeback_if #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .PC_WIDTH(32)) u_if ();

`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  writeback #(.DWIDTH(32), .AWIDTH(5), .FUNCT_WIDTH(3), .PC_WIDTH(32)) dut (
    .c_clk (c_clk),
    .c_rst (c_rst),
    .wb    (u_if)
`ifdef WB_INSTRET_EN
    ,
    .wb_o_instret (instret)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [63:0] m_instret;
  bit          cmp_en = 0;

  function automatic logic [31:0] expect_data(input ent_t e);
    longint unsigned v;
    case (e.src)
      2'b00: return e.alu;
      2'b10: return e.pc + 32'd4;
      2'b01: begin
        case (e.f3)
          3'd0, 3'd4: begin
            v = (longint'(e.ld) >> (8 * e.off)) % 256;
            if (e.f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
            return v[31:0];
          end
          3'd1, 3'd5: begin
            v = (longint'(e.ld) >> (16 * (e.off / 2))) % 65536;
            if (e.f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
            return v[31:0];
          end
          default: return e.ld;
        endcase
      end
      default: return e.alu;
    endcase
  endfunction

  always @(posedge c_clk or posedge c_rst) begin
    if (c_rst) begin
      q.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_instret = 0;
    end else begin
      bit   can_take, do_pop, do_push;
      ent_t e, n;
      can_take = q.size() < 2;
      do_pop   = q.size() > 0 && !u_if.wb_i_stall && !u_if.wb_i_flush;
      do_push  = u_if.wb_i_valid && can_take && !u_if.wb_i_flush;
      n.src = u_if.wb_i_src; n.f3 = u_if.wb_i_funct3; n.off = u_if.wb_i_byte_off;
      n.rd = u_if.wb_i_addr_rd; n.alu = u_if.wb_i_alu; n.ld = u_if.wb_i_load;
      n.pc = u_if.wb_i_pc;
      if (u_if.wb_i_flush) begin
        q.delete();
        m_we = 0;
      end else begin
        if (do_pop) begin
          e = q.pop_front();
          m_we   = (e.src != 2'b11) && (e.rd != 0);
          m_addr = e.rd;
          m_data = expect_data(e);
          m_instret = m_instret + 1;
        end else m_we = 0;
        if (do_push) q.push_back(n);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge c_clk) begin
    if (cmp_en && !c_rst) begin
      chk("cyc_we",    u_if.wb_o_we,       m_we);
      chk("cyc_addr",  u_if.wb_o_addr_rd,  m_addr);
      chk("cyc_data",  u_if.wb_o_data_rd,  m_data);
      chk("cyc_ready", u_if.wb_o_ready,    q.size() < 2);
`ifdef WB_INSTRET_EN
      chk("cyc_instret", instret, m_instret);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
    u_if.wb_i_valid = v;    u_if.wb_i_src = src;     u_if.wb_i_funct3 = f3;
    u_if.wb_i_byte_off = off; u_if.wb_i_addr_rd = rd; u_if.wb_i_alu = alu;
    u_if.wb_i_load = ld;    u_if.wb_i_pc = pc;
  endtask

  // One entry into an empty, unstalled buffer; checks the write one edge later.
  task automatic send1(input string nm, input logic [1:0] src, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc,
                       input logic exp_we, input logic [31:0] exp_data);
    drive(1'b1, src, f3, off, rd, alu, ld, pc);
    step();
    u_if.wb_i_valid = 1'b0;
    step();
    chk({nm, "_we"}, u_if.wb_o_we, exp_we);
    if (exp_we) begin
      chk({nm, "_addr"}, u_if.wb_o_addr_rd, rd);
      chk({nm, "_data"}, u_if.wb_o_data_rd, exp_data);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef WB_INSTRET_EN
    logic [63:0] ir0;
`endif
    u_if.wb_i_flush = 0;
    u_if.wb_i_stall = 0;
    drive(1'b0, 2'b00, 3'd0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    c_rst = 1'b1;
    step(); step();
    chk("rst_we",    u_if.wb_o_we,      1'b0);
    chk("rst_addr",  u_if.wb_o_addr_rd, 5'd0);
    chk("rst_data",  u_if.wb_o_data_rd, 32'd0);
    chk("rst_ready", u_if.wb_o_ready,   1'b1);
    c_rst = 1'b0;
    cmp_en = 1;

    // ALU write with one-cycle latency, then the enable drops.
    send1("alu", 2'b00, 3'd0, 2'd0, 5'd5, 32'h1234, 32'd0, 32'd0, 1'b1, 32'h0000_1234);
    step();
    chk("alu_we_drop", u_if.wb_o_we, 1'b0);

    // Load extensions on 0x80FF7F01.
    send1("lb3",  2'b01, 3'd0, 2'd3, 5'd1, 32'd0, 32'h80FF7F01, 32'd0, 1'b1, 32'hFFFF_FF80);
    send1("lbu1", 2'b01, 3'd4, 2'd1, 5'd2, 32'd0, 32'h80FF7F01, 32'd0, 1'b1, 32'h0000_007F);
    send1("lh2",  2'b01, 3'd1, 2'd2, 5'd3, 32'd0, 32'h80FF7F01, 32'd0, 1'b1, 32'hFFFF_80FF);
    send1("lhu1", 2'b01, 3'd5, 2'd1, 5'd4, 32'd0, 32'h80FF7F01, 32'd0, 1'b1, 32'h0000_7F01);
    send1("lw",   2'b01, 3'd2, 2'd3, 5'd6, 32'd0, 32'h80FF7F01, 32'd0, 1'b1, 32'h80FF_7F01);

    // No-write cases still retire.
`ifdef WB_INSTRET_EN
    ir0 = instret;
`endif
    send1("x0",    2'b00, 3'd0, 2'd0, 5'd0, 32'hDEAD, 32'd0, 32'd0, 1'b0, 32'd0);
    send1("nowr",  2'b11, 3'd0, 2'd0, 5'd7, 32'hBEEF, 32'd0, 32'd0, 1'b0, 32'd0);
`ifdef WB_INSTRET_EN
    chk("instret_nowr", instret, ir0 + 64'd2);
`endif

    // Stall: two accepts fill the buffer, the third waits.
    u_if.wb_i_stall = 1;
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd10, 32'hA, 32'd0, 32'd0); step();
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd11, 32'hB, 32'd0, 32'd0); step();
    chk("stall_ready2", u_if.wb_o_ready, 1'b0);
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd12, 32'hC, 32'd0, 32'd0); step();
    chk("stall_ready3", u_if.wb_o_ready, 1'b0);
    chk("stall_we",     u_if.wb_o_we,    1'b0);
    u_if.wb_i_stall = 0;
    step();
    chk("stall_wA", u_if.wb_o_we, 1'b1);
    chk("stall_dA", u_if.wb_o_data_rd, 32'hA);
    step();
    u_if.wb_i_valid = 0;
    chk("stall_wB", u_if.wb_o_we, 1'b1);
    chk("stall_dB", u_if.wb_o_data_rd, 32'hB);
    step();
    chk("stall_wC", u_if.wb_o_we, 1'b1);
    chk("stall_dC", u_if.wb_o_data_rd, 32'hC);
    chk("stall_aC", u_if.wb_o_addr_rd, 5'd12);
    step();
    chk("stall_end", u_if.wb_o_we, 1'b0);

    // Flush with two buffered entries plus a valid input.
    u_if.wb_i_stall = 1;
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd13, 32'h11, 32'd0, 32'd0); step();
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd14, 32'h22, 32'd0, 32'd0); step();
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd15, 32'h33, 32'd0, 32'd0);
    u_if.wb_i_flush = 1;
    step();
    u_if.wb_i_flush = 0; u_if.wb_i_stall = 0; u_if.wb_i_valid = 0;
    chk("flush_ready", u_if.wb_o_ready, 1'b1);
    chk("flush_we0",   u_if.wb_o_we,    1'b0);
    step();
    chk("flush_we1",   u_if.wb_o_we,    1'b0);
    step();
    chk("flush_we2",   u_if.wb_o_we,    1'b0);
    send1("pc4", 2'b10, 3'd0, 2'd0, 5'd8, 32'd0, 32'd0, 32'h100, 1'b1, 32'h0000_0104);

    // Asynchronous reset between edges while the write enable is high.
    u_if.wb_i_stall = 1;
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd20, 32'h55, 32'd0, 32'd0); step();
    drive(1'b1, 2'b00, 3'd0, 2'd0, 5'd21, 32'h66, 32'd0, 32'd0); step();
    u_if.wb_i_valid = 0; u_if.wb_i_stall = 0;
    step();
    chk("prerst_we", u_if.wb_o_we, 1'b1);
    #2;
    c_rst = 1'b1;
    #1;
    chk("arst_we",    u_if.wb_o_we,      1'b0);
    chk("arst_ready", u_if.wb_o_ready,   1'b1);
    chk("arst_data",  u_if.wb_o_data_rd, 32'd0);
    c_rst = 1'b0;
    step();
    chk("postrst_we1", u_if.wb_o_we, 1'b0);
    step();
    chk("postrst_we2", u_if.wb_o_we, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom);
      u_if.wb_i_stall = $urandom_range(0, 3) == 0;
      u_if.wb_i_flush = $urandom_range(0, 19) == 0;
      step();
    end
    u_if.wb_i_valid = 0; u_if.wb_i_stall = 0; u_if.wb_i_flush = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
